// File: rtl/cmp8_arbiter.sv
// Round-robin shared 8-bit magnitude comparator: NREQ requesters, two-stage pipeline
// (operand register S1, comparator + result register S2), id-tagged results.

module cmp8
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       greater,
  output logic       less
);

  assign greater = (a > b);
  assign less    = (a < b);

endmodule

module cmp8_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*8-1:0]             req_a,
  input  logic [NREQ*8-1:0]             req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NREQ)-1:0]       res_id,
  output logic                          res_gt,
  output logic                          res_lt,
  output logic                          res_eq,
  output logic                          busy
);

  localparam int ID_W = $clog2(NREQ);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Producers hold valid and data until that edge; ready never looks at the data.

  logic [ID_W-1:0] ptr;
  logic            s1_full;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic [ID_W-1:0] s1_id;
  logic            s2_full;
  logic [ID_W-1:0] s2_id;
  logic            s2_gt;
  logic            s2_lt;
  logic            s2_eq;

  logic            s2_free;
  logic            s1_free;
  logic            found;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic            accept;
  logic            cmp_gt;
  logic            cmp_lt;

  assign s2_free = !s2_full || res_ready;
  assign s1_free = !s1_full || s2_free;

  // Search starts just after the last granted id, so the most recent winner goes last.
  always_comb begin
    found     = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    if (s1_free && found) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  cmp8 u_cmp8 (
    .a       (s1_a),
    .b       (s1_b),
    .greater (cmp_gt),
    .less    (cmp_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= ID_W'(NREQ - 1);
      s1_full <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_id   <= '0;
    end else begin
      if (accept) begin
        ptr     <= gnt_id;
        s1_full <= 1'b1;
        s1_a    <= req_a[8*gnt_id +: 8];
        s1_b    <= req_b[8*gnt_id +: 8];
        s1_id   <= gnt_id;
      end else if (s2_free) begin
        s1_full <= 1'b0;
      end
    end
  end

  // S2 loads whenever it frees up; an empty S1 leaves the old flags but clears s2_full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_full <= 1'b0;
      s2_id   <= '0;
      s2_gt   <= 1'b0;
      s2_lt   <= 1'b0;
      s2_eq   <= 1'b0;
    end else if (s2_free) begin
      s2_full <= s1_full;
      if (s1_full) begin
        s2_id <= s1_id;
        s2_gt <= cmp_gt;
        s2_lt <= cmp_lt;
        s2_eq <= !cmp_gt && !cmp_lt;
      end
    end
  end

  assign res_valid = s2_full;
  assign res_id    = s2_id;
  assign res_gt    = s2_gt;
  assign res_lt    = s2_lt;
  assign res_eq    = s2_eq;
  assign busy      = s1_full || s2_full;

endmodule

// File: tb/tb_cmp8_arbiter.sv
// Randomized and directed bench for cmp8_arbiter against a queue-based
// transaction model (in-flight pairs with acceptance time, round-robin pointer).

module tb_cmp8_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [ID_W-1:0]   res_id;
  logic              res_gt;
  logic              res_lt;
  logic              res_eq;
  logic              busy;

  always #5 clk = ~clk;

  cmp8_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_gt    (res_gt),
    .res_lt    (res_lt),
    .res_eq    (res_eq),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    int         acc;
  } item_t;

  item_t exp_q[$];
  int    acc_log[$];
  int    mptr;
  int    cyc;
  int    n_checks;
  int    n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    acc_log.delete();
    mptr = NREQ - 1;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, input logic rn);
    bit   vis;
    bit   allowed;
    int   g;
    int   idx;
    logic [3:0] exp_ready;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    rst_n     = rn;
    #1;
    vis     = (exp_q.size() > 0) && ((cyc - exp_q[0].acc) >= 1);
    allowed = (exp_q.size() < 2) || (vis && rr);
    g = -1;
    if (allowed) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(vis));
    check("busy", 32'(busy), 32'(exp_q.size() > 0));
    if (vis) begin
      check("res_id", 32'(res_id), 32'(exp_q[0].id));
      check("res_gt", 32'(res_gt), 32'(exp_q[0].a > exp_q[0].b));
      check("res_lt", 32'(res_lt), 32'(exp_q[0].a < exp_q[0].b));
      check("res_eq", 32'(res_eq), 32'(exp_q[0].a == exp_q[0].b));
    end
    @(posedge clk);
    cyc++;
    if (!rn) begin
      model_clear();
    end else begin
      if (vis && rr) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back('{id: g, a: a[8*g +: 8], b: b[8*g +: 8], acc: cyc});
        mptr = g;
        acc_log.push_back(g);
      end
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] bnd_a;
  logic [31:0] bnd_b;
  logic [2:0]  bnd_f [4];
  int          n_acc;
  int          guard;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_flags", 32'({res_gt, res_lt, res_eq}), 32'd0);

    // Single requester id 2
    step(4'b0100, pack(8'h0, 8'h0, 8'hA5, 8'h0), pack(8'h0, 8'h0, 8'h5A, 8'h0), 1'b1, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_id", 32'(res_id), 32'd2);
    check("t1_gt", 32'(res_gt), 32'd1);
    step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    // All four valid every cycle
    do_reset();
    for (int k = 0; k < 8; k++)
      step(4'b1111, pack(8'd3, 8'd9, 8'hA5, 8'h00), pack(8'd7, 8'd9, 8'h5A, 8'hFF), 1'b1, 1'b1);
    check("t2_accepts", 32'(acc_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++)
      check("t2_order", 32'(acc_log[k]), 32'(k % 4));
    repeat (3) step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    // Boundary pairs through requester 0, back to back
    do_reset();
    bnd_a = {8'hFF, 8'h80, 8'hFF, 8'h00};
    bnd_b = {8'hFF, 8'h7F, 8'h00, 8'hFF};
    bnd_f[0] = 3'b010; bnd_f[1] = 3'b100; bnd_f[2] = 3'b100; bnd_f[3] = 3'b001;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(4'b0001, 32'(bnd_a[8*k +: 8]), 32'(bnd_b[8*k +: 8]), 1'b1, 1'b1);
      else       step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
      #1;
      if (k >= 1) check("t3_flags", 32'({res_gt, res_lt, res_eq}), 32'(bnd_f[k-1]));
    end

    // Back-pressure: three active requesters, consumer stalled
    do_reset();
    repeat (5) step(4'b0111, pack(8'd1, 8'd2, 8'd3, 8'd0), pack(8'd2, 8'd2, 8'd2, 8'd0), 1'b0, 1'b1);
    #1;
    check("t4_accepted", 32'(acc_log.size()), 32'd2);
    check("t4_ready_low", 32'(req_ready), 32'd0);
    check("t4_head_id", 32'(res_id), 32'd0);
    step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("t4_second_id", 32'(res_id), 32'd1);
    repeat (2) step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    // Sparse: ids 1 and 3 only, pointer parked on 1
    do_reset();
    step(4'b0010, pack(8'd0, 8'd5, 8'd0, 8'd6), pack(8'd0, 8'd5, 8'd0, 8'd6), 1'b1, 1'b1);
    repeat (2) step(4'b1010, pack(8'd0, 8'd5, 8'd0, 8'd6), pack(8'd0, 8'd4, 8'd0, 8'd7), 1'b1, 1'b1);
    check("t5_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() == 3) begin
      check("t5_first", 32'(acc_log[1]), 32'd3);
      check("t5_second", 32'(acc_log[2]), 32'd1);
    end
    repeat (2) step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset with both stages full
    do_reset();
    repeat (3) step(4'b1111, 32'h12345678, 32'h87654321, 1'b0, 1'b1);
    step(4'b1111, 32'h12345678, 32'h87654321, 1'b0, 1'b0);
    #1;
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    step(4'b1111, 32'h12345678, 32'h87654321, 1'b1, 1'b1);
    check("t6_first_grant", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd0);
    repeat (2) step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    // Random traffic until 10000 pairs accepted (bounded)
    do_reset();
    n_acc = 0;
    guard = 0;
    while (n_acc < 10000 && guard < 30000) begin
      step(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0), 1'b1);
      n_acc += acc_log.size();
      acc_log.delete();
      guard++;
    end
    check("rand_accepts_reached", 32'(n_acc >= 10000), 32'd1);
    repeat (3) step(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
